// File: rtl/mixer_mc_pkg.sv
// Shared types and elaboration helpers for the multichannel mixer.
// Pan codes are per channel; panning_t is the global preset mapped onto them.
package mixer_mc_pkg;

    typedef enum logic [1:0] {
        PAN_OFF = 2'd0,
        PAN_L   = 2'd1,
        PAN_R   = 2'd2,
        PAN_LR  = 2'd3
    } pan_t;

    typedef enum logic [1:0] {
        PANNING_ABC  = 2'd0,
        PANNING_ACB  = 2'd1,
        PANNING_MONO = 2'd2
    } panning_t;

    localparam int unsigned ATT_W = 2;
    localparam int unsigned PAN_W = 2;

    // AY channels come in triples (A, B, C); the preset picks which one sits centre.
    function automatic pan_t preset_pan(input panning_t p, input int unsigned ch);
        pan_t r;
        r = PAN_LR;
        case (p)
            PANNING_ABC: begin
                case (ch % 3)
                    0:       r = PAN_L;
                    1:       r = PAN_LR;
                    default: r = PAN_R;
                endcase
            end
            PANNING_ACB: begin
                case (ch % 3)
                    0:       r = PAN_L;
                    1:       r = PAN_R;
                    default: r = PAN_LR;
                endcase
            end
            default: r = PAN_LR;
        endcase
        return r;
    endfunction

    function automatic longint unsigned worst_sum(
        input int unsigned chans, input int unsigned sw,
        input int unsigned beep,  input int unsigned tape
    );
        return longint'(chans) * ((longint'(1) << sw) - 1) + longint'(beep) + 2 * longint'(tape);
    endfunction

    // Narrowest accumulator, never below OUT_W+2, that holds the worst-case frame sum.
    function automatic int unsigned acc_width(
        input int unsigned chans, input int unsigned sw, input int unsigned ow,
        input int unsigned beep,  input int unsigned tape
    );
        longint unsigned worst;
        int unsigned     w;
        worst = worst_sum(chans, sw, beep, tape);
        w     = ow + 2;
        for (int i = 0; i < 64; i++)
            if ((longint'(1) << w) <= worst) w = w + 1;
        return w;
    endfunction

endpackage

// File: rtl/mixer_mc_sdac.sv
// First-order sigma-delta DAC: the carry out of a W-bit phase accumulator is the bit stream.
module sigma_delta_dac #(
    parameter int unsigned W = 10
) (
    input  logic         clk28,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic         dout
);

    logic [W:0] r_sd;
    logic       r_dout;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_sd   <= '0;
            r_dout <= 1'b0;
        end else begin
            r_sd   <= {1'b0, r_sd[W-1:0]} + {1'b0, din};
            r_dout <= r_sd[W];
        end
    end

    assign dout = r_dout;

endmodule

// File: rtl/mixer_mc.sv
// Time-multiplexed N-channel mixer: one channel per slot, a final slot that adds
// beeper/tape, saturates and latches the sample, then two sigma-delta DACs.
module mixer_mc
    import mixer_mc_pkg::*;
#(
    parameter int unsigned CHANNELS     = 16,
    parameter int unsigned SAMPLE_W     = 8,
    parameter int unsigned OUT_W        = 10,
    parameter int unsigned BEEPER_LEVEL = 128,
    parameter int unsigned TAPE_LEVEL   = 32
) (
    input  logic                         clk28,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_data,
    input  logic [2*CHANNELS-1:0]        ch_pan,
    input  logic [2*CHANNELS-1:0]        ch_att,
    input  logic                         mono,
    input  logic                         beeper,
    input  logic                         tape_out,
    input  logic                         tape_in,
    output logic [OUT_W-1:0]             sample_l,
    output logic [OUT_W-1:0]             sample_r,
    output logic                         sample_strobe,
    output logic                         clip,
    output logic                         dac_l,
    output logic                         dac_r
);

    // Widened beyond OUT_W+2 only when the channel count demands it, so sums never wrap.
    localparam int unsigned     ACC_W  = acc_width(CHANNELS, SAMPLE_W, OUT_W, BEEPER_LEVEL, TAPE_LEVEL);
    localparam longint unsigned WORST  = worst_sum(CHANNELS, SAMPLE_W, BEEPER_LEVEL, TAPE_LEVEL);
    localparam int unsigned     SLOT_W = $clog2(CHANNELS + 1);

    localparam logic [ACC_W-1:0]  BEEP_C = ACC_W'(BEEPER_LEVEL);
    localparam logic [ACC_W-1:0]  TAPE_C = ACC_W'(TAPE_LEVEL);
    localparam logic [SLOT_W-1:0] LAST   = SLOT_W'(CHANNELS);

    generate
        if (CHANNELS < 2 || CHANNELS > 32) begin : g_bad_channels
            $error("mixer_mc: CHANNELS must be within 2..32");
        end
        if ((longint'(1) << ACC_W) <= WORST) begin : g_bad_acc
            $error("mixer_mc: accumulator too narrow for worst-case sum");
        end
        if (SAMPLE_W > ACC_W) begin : g_bad_sample
            $error("mixer_mc: SAMPLE_W wider than accumulator");
        end
    endgenerate

    logic [SLOT_W-1:0]   r_slot;
    logic [ACC_W-1:0]    r_acc_l;
    logic [ACC_W-1:0]    r_acc_r;
    logic [OUT_W-1:0]    r_sample_l;
    logic [OUT_W-1:0]    r_sample_r;
    logic                r_strobe;
    logic                r_clip;

    logic [SAMPLE_W-1:0] w_raw;
    logic [ATT_W-1:0]    w_att;
    pan_t                w_pan;
    logic [ACC_W-1:0]    w_v;
    logic                w_add_l;
    logic                w_add_r;
    logic                w_last;
    logic [ACC_W-1:0]    w_extra;
    logic [ACC_W-1:0]    w_sum_l;
    logic [ACC_W-1:0]    w_sum_r;
    logic                w_sat_l;
    logic                w_sat_r;
    logic [OUT_W-1:0]    w_mix_l;
    logic [OUT_W-1:0]    w_mix_r;

    // Slot mux; the final slot selects nothing and leaves w_pan at PAN_OFF.
    always_comb begin
        w_raw = '0;
        w_att = '0;
        w_pan = PAN_OFF;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_raw = ch_data[i*SAMPLE_W +: SAMPLE_W];
                w_att = ch_att[i*ATT_W +: ATT_W];
                w_pan = pan_t'(ch_pan[i*PAN_W +: PAN_W]);
            end
        end
    end

    assign w_v     = ACC_W'(w_raw >> w_att);
    assign w_add_l = (w_pan == PAN_L) || (w_pan == PAN_LR) || (mono && (w_pan != PAN_OFF));
    assign w_add_r = (w_pan == PAN_R) || (w_pan == PAN_LR) || (mono && (w_pan != PAN_OFF));
    assign w_last  = (r_slot == LAST);

    assign w_extra = (beeper   ? BEEP_C : '0)
                   + (tape_out ? TAPE_C : '0)
                   + (tape_in  ? TAPE_C : '0);
    assign w_sum_l = r_acc_l + w_extra;
    assign w_sum_r = r_acc_r + w_extra;
    assign w_sat_l = |w_sum_l[ACC_W-1:OUT_W];
    assign w_sat_r = |w_sum_r[ACC_W-1:OUT_W];
    assign w_mix_l = w_sat_l ? '1 : w_sum_l[OUT_W-1:0];
    assign w_mix_r = w_sat_r ? '1 : w_sum_r[OUT_W-1:0];

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            r_slot     <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_strobe   <= 1'b0;
            r_clip     <= 1'b0;
        end else if (!en) begin
            r_slot     <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_sample_l <= '0;
            r_sample_r <= '0;
            r_strobe   <= 1'b0;
            r_clip     <= 1'b0;
        end else if (w_last) begin
            r_slot     <= '0;
            r_acc_l    <= '0;
            r_acc_r    <= '0;
            r_sample_l <= w_mix_l;
            r_sample_r <= w_mix_r;
            r_strobe   <= 1'b1;
            r_clip     <= w_sat_l | w_sat_r;
        end else begin
            r_slot     <= r_slot + 1'b1;
            r_strobe   <= 1'b0;
            r_clip     <= 1'b0;
            if (w_add_l) r_acc_l <= r_acc_l + w_v;
            if (w_add_r) r_acc_r <= r_acc_r + w_v;
        end
    end

    assign sample_l      = r_sample_l;
    assign sample_r      = r_sample_r;
    assign sample_strobe = r_strobe;
    assign clip          = r_clip;

    sigma_delta_dac #(.W(OUT_W)) u_sd_l (
        .clk28 (clk28),
        .rst_n (rst_n),
        .din   (r_sample_l),
        .dout  (dac_l)
    );

    sigma_delta_dac #(.W(OUT_W)) u_sd_r (
        .clk28 (clk28),
        .rst_n (rst_n),
        .din   (r_sample_r),
        .dout  (dac_r)
    );

endmodule

// File: tb/tb_mixer_mc.sv
// Directed bench for mixer_mc with four channels (five-cycle frame).
module tb_mixer_mc;

    localparam int CH = 4;
    localparam int SW = 8;
    localparam int OW = 10;

    logic            clk28    = 1'b0;
    logic            rst_n    = 1'b0;
    logic            en       = 1'b0;
    logic            mono     = 1'b0;
    logic            beeper   = 1'b0;
    logic            tape_out = 1'b0;
    logic            tape_in  = 1'b0;
    logic [CH*SW-1:0] ch_data = '0;
    logic [2*CH-1:0]  ch_pan  = '0;
    logic [2*CH-1:0]  ch_att  = '0;
    logic [OW-1:0]    sample_l;
    logic [OW-1:0]    sample_r;
    logic             sample_strobe;
    logic             clip;
    logic             dac_l;
    logic             dac_r;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk28 = ~clk28;

    mixer_mc #(
        .CHANNELS(CH), .SAMPLE_W(SW), .OUT_W(OW),
        .BEEPER_LEVEL(128), .TAPE_LEVEL(32)
    ) dut (
        .clk28(clk28), .rst_n(rst_n), .en(en),
        .ch_data(ch_data), .ch_pan(ch_pan), .ch_att(ch_att),
        .mono(mono), .beeper(beeper), .tape_out(tape_out), .tape_in(tape_in),
        .sample_l(sample_l), .sample_r(sample_r),
        .sample_strobe(sample_strobe), .clip(clip),
        .dac_l(dac_l), .dac_r(dac_r)
    );

    task automatic tick();
        @(posedge clk28);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_ch();
        ch_data = '0;
        ch_pan  = '0;
        ch_att  = '0;
    endtask

    task automatic set_ch(input int i, input logic [7:0] d, input logic [1:0] p, input logic [1:0] a);
        ch_data[i*SW +: SW] = d;
        ch_pan[2*i +: 2]    = p;
        ch_att[2*i +: 2]    = a;
    endtask

    task automatic wait_strobe(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            tick();
            if (sample_strobe === 1'b1) seen = 1'b1;
        end
        chk({tag, "_strobe_seen"}, 32'(seen), 32'd1);
    endtask

    // Two strobes: the first frame may mix old and new settings.
    task automatic check_mix(input string tag, input int el, input int er, input logic ec);
        wait_strobe({tag, "_align"});
        wait_strobe(tag);
        chk({tag, "_l"},    32'(sample_l), 32'(el));
        chk({tag, "_r"},    32'(sample_r), 32'(er));
        chk({tag, "_clip"}, 32'(clip),     32'(ec));
        tick();
        chk({tag, "_strobe_drop"}, 32'(sample_strobe), 32'd0);
        chk({tag, "_clip_drop"},   32'(clip),          32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ones_l;
        int ones_r;

        en = 1'b1;
        tick();
        tick();
        chk("rst_sample_l", 32'(sample_l), 32'd0);
        chk("rst_sample_r", 32'(sample_r), 32'd0);
        chk("rst_strobe",   32'(sample_strobe), 32'd0);
        chk("rst_clip",     32'(clip), 32'd0);
        chk("rst_dac",      {30'd0, dac_l, dac_r}, 32'd0);

        // 1: silence, strobe every fifth cycle
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk("t1_strobe", 32'(sample_strobe), 32'((k % 5) == 0));
            chk("t1_samples", {6'd0, sample_l, sample_r}, 32'd0);
            chk("t1_dac", {30'd0, dac_l, dac_r}, 32'd0);
        end

        // 2: single left channel and its DAC density
        set_ch(0, 8'h80, 2'd1, 2'd0);
        wait_strobe("t2");
        chk("t2_l", 32'(sample_l), 32'd128);
        chk("t2_r", 32'(sample_r), 32'd0);
        tick();
        ones_l = 0;
        ones_r = 0;
        for (int k = 0; k < 1024; k++) begin
            tick();
            ones_l += int'(dac_l);
            ones_r += int'(dac_r);
        end
        chk("t2_dac_l_ones", 32'(ones_l), 32'd128);
        chk("t2_dac_r_ones", 32'(ones_r), 32'd0);

        // 3: full-scale on both sides plus beeper saturates
        for (int i = 0; i < CH; i++) set_ch(i, 8'hFF, 2'd3, 2'd0);
        beeper = 1'b1;
        check_mix("t3", 1023, 1023, 1'b1);

        // 4: mono fold, then stereo
        clr_ch();
        beeper = 1'b0;
        set_ch(0, 8'h40, 2'd1, 2'd0);
        set_ch(1, 8'h20, 2'd2, 2'd0);
        mono = 1'b1;
        check_mix("t4_mono", 96, 96, 1'b0);
        mono = 1'b0;
        check_mix("t4_stereo", 64, 32, 1'b0);

        // 5: attenuation and tape input
        clr_ch();
        set_ch(2, 8'hFF, 2'd2, 2'd3);
        tape_in = 1'b1;
        check_mix("t5", 32, 63, 1'b0);

        // 6: reset mid-frame at slot 2
        wait_strobe("t6_align");
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_samples", {6'd0, sample_l, sample_r}, 32'd0);
        chk("t6_rst_strobe",  32'(sample_strobe), 32'd0);
        chk("t6_rst_dac",     {30'd0, dac_l, dac_r}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t6_rel_strobe", 32'(sample_strobe), 32'(k == 5));
        end
        chk("t6_rel_l", 32'(sample_l), 32'd32);
        chk("t6_rel_r", 32'(sample_r), 32'd63);

        // drop en at slot 3
        tick();
        tick();
        tick();
        en = 1'b0;
        tick();
        chk("t6_en_samples", {6'd0, sample_l, sample_r}, 32'd0);
        chk("t6_en_strobe",  32'(sample_strobe), 32'd0);
        tick();
        tick();
        for (int k = 0; k < 6; k++) begin
            chk("t6_off_dac",     {30'd0, dac_l, dac_r}, 32'd0);
            chk("t6_off_strobe",  32'(sample_strobe), 32'd0);
            chk("t6_off_samples", {6'd0, sample_l, sample_r}, 32'd0);
            tick();
        end
        en = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("t6_en_strobe_back", 32'(sample_strobe), 32'(k == 5));
        end
        chk("t6_en_r", 32'(sample_r), 32'd63);
        chk("t6_en_l", 32'(sample_l), 32'd32);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
